// File: rtl/pb_hex_entry_pkg.sv
// Shared key indices, FSM state and decoded-event types for the pushbutton hex entry block.
package pb_hex_entry_pkg;

  localparam int KEY_CLEAR = 16;
  localparam int KEY_BKSP  = 17;
  localparam int KEY_ENTER = 18;
  localparam int PB_WIDTH  = 21;

  typedef enum logic {
    ENTRY,
    DONE
  } entry_state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CLEAR,
    EV_BKSP,
    EV_ENTER,
    EV_DIGIT
  } key_event_t;

endpackage

// File: rtl/pb_hex_entry_debounce.sv
// Two-flop synchronizer plus whole-vector stability debounce; rise_o marks new presses.
module pb_debounce #(
  parameter int WIDTH      = 21,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] rise_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic [WIDTH-1:0] s1_q, s2_q, cand_q, stable_q, stable_prev_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
    end else begin
      s1_q          <= raw_i;
      s2_q          <= s1_q;
      stable_prev_q <= stable_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_MAX - 1'b1)
          stable_q <= cand_q;
      end
    end
  end

  // Combinational so the owning FSM registers the event one edge after stable moves.
  assign rise_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/pb_hex_entry.sv
// Pushbutton hex-digit entry: debounce, priority key decode, digit buffer and commit FSM.
// Optional macro PB_HEX_ENTRY_BLANK_EN enables per-digit blanking of unentered digits.
//
// state | meaning
// ENTRY | digits, backspace and enter are accepted
// DONE  | value committed; only CLEAR or BKSP (resume editing) act
module pb_hex_entry
  import pb_hex_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [PB_WIDTH-1:0]               pb,
  output logic [4*NUM_DIGITS-1:0]           digits_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count_o,
  output logic [4*NUM_DIGITS-1:0]           value_o,
  output logic                              value_valid_o,
  output logic                              key_strobe_o,
  output logic                              overflow_o,
  output logic [NUM_DIGITS-1:0]             blank_mask_o
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int BW = 4 * NUM_DIGITS;

  logic [PB_WIDTH-1:0] rise;
  key_event_t          ev;
  logic [3:0]          ev_digit;
  logic                unused_rise;

  entry_state_t        state_q;
  logic [BW-1:0]       buf_q, value_q;
  logic [CW-1:0]       count_q;
  logic                valid_q, strobe_q, ovf_q;

  logic full, in_entry;
  logic do_clear, do_digit, do_ovf, do_bksp, do_enter, do_resume;

  pb_debounce #(
    .WIDTH      (PB_WIDTH),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (pb),
    .rise_o (rise)
  );

  assign unused_rise = ^rise[PB_WIDTH-1:KEY_ENTER+1];

  // Descending scan so the lowest-index hex key wins when several coincide.
  always_comb begin
    ev       = EV_NONE;
    ev_digit = 4'h0;
    if (rise[KEY_CLEAR])      ev = EV_CLEAR;
    else if (rise[KEY_BKSP])  ev = EV_BKSP;
    else if (rise[KEY_ENTER]) ev = EV_ENTER;
    else begin
      for (int i = 15; i >= 0; i--) begin
        if (rise[i]) begin
          ev       = EV_DIGIT;
          ev_digit = 4'(i);
        end
      end
    end
  end

  assign full      = (count_q == CW'(NUM_DIGITS));
  assign in_entry  = (state_q == ENTRY);
  assign do_clear  = (ev == EV_CLEAR);
  assign do_digit  = (ev == EV_DIGIT) && in_entry && !full;
  assign do_ovf    = (ev == EV_DIGIT) && in_entry && full;
  assign do_bksp   = (ev == EV_BKSP) && in_entry && (count_q != '0);
  assign do_enter  = (ev == EV_ENTER) && in_entry;
  assign do_resume = (ev == EV_BKSP) && !in_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ENTRY;
      buf_q    <= '0;
      count_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      if (do_clear) begin
        buf_q    <= '0;
        count_q  <= '0;
        state_q  <= ENTRY;
        strobe_q <= 1'b1;
      end else if (do_digit) begin
        buf_q    <= {buf_q[BW-5:0], ev_digit};
        count_q  <= count_q + 1'b1;
        strobe_q <= 1'b1;
      end else if (do_ovf) begin
        ovf_q    <= 1'b1;
        strobe_q <= 1'b1;
      end else if (do_bksp) begin
        buf_q    <= {4'h0, buf_q[BW-1:4]};
        count_q  <= count_q - 1'b1;
        strobe_q <= 1'b1;
      end else if (do_enter) begin
        value_q  <= buf_q;
        valid_q  <= 1'b1;
        state_q  <= DONE;
        strobe_q <= 1'b1;
      end else if (do_resume) begin
        state_q  <= ENTRY;
        strobe_q <= 1'b1;
      end
    end
  end

`ifdef PB_HEX_ENTRY_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q;

  // Thermometer code tracking count: bit i set while digit i holds an entered value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         blank_q <= '0;
    else if (do_clear) blank_q <= '0;
    else if (do_digit) blank_q <= {blank_q[NUM_DIGITS-2:0], 1'b1};
    else if (do_bksp)  blank_q <= {1'b0, blank_q[NUM_DIGITS-1:1]};
  end

  assign blank_mask_o = blank_q;
`else
  assign blank_mask_o = '1;
`endif

  assign digits_o      = buf_q;
  assign count_o       = count_q;
  assign value_o       = value_q;
  assign value_valid_o = valid_q;
  assign key_strobe_o  = strobe_q;
  assign overflow_o    = ovf_q;

endmodule
